// File: rtl/ex_stage_execute_unit.sv
// ---------------------------------------------------------------------------
// ex_stage_execute_unit
//
// Execute stage of the 64-bit LEGv8 pipeline. It decodes the ALU function,
// selects operand B, runs the ALU and computes the branch target
// pc + (imm << 2). The ALU result, zero flag and branch target are captured
// in the EX/MEM output register.
//
// Ports
//   clk            : rising-edge clock
//   register_reset : synchronous active-high reset of the output register
//   register_write : output register load enable
//   alu_op         : ALUOperation from ID/EX
//   alu_src        : 0 selects read_data_2, 1 selects extended_data as B
//   opcode         : instruction[31:21]
//   pc             : PC of the instruction in EX
//   read_data_1    : operand A
//   read_data_2    : register operand B
//   extended_data  : sign-extended immediate
//   alu_func       : decoded ALU function (combinational)
//   alu_result     : registered ALU result
//   alu_zero       : registered zero flag
//   jump_address   : registered branch target
//
// Handshake: none. The stage accepts one instruction on every enabled edge
// and its registered outputs are valid one edge after the inputs.
// ---------------------------------------------------------------------------

// Shared adder primitive: S = A + B + Cin, carry-out dropped.
module ex_stage_adder #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o
);
  assign sum_o = a_i + b_i + {{(WIDTH-1){1'b0}}, cin_i};
endmodule

module ex_stage_execute_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             register_reset,
  input  logic             register_write,
  input  logic [1:0]       alu_op,
  input  logic             alu_src,
  input  logic [10:0]      opcode,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] read_data_1,
  input  logic [WIDTH-1:0] read_data_2,
  input  logic [WIDTH-1:0] extended_data,
  output logic [3:0]       alu_func,
  output logic [WIDTH-1:0] alu_result,
  output logic             alu_zero,
  output logic [WIDTH-1:0] jump_address
);

  localparam logic [3:0] FUNC_AND   = 4'b0000;
  localparam logic [3:0] FUNC_ORR   = 4'b0001;
  localparam logic [3:0] FUNC_ADD   = 4'b0010;
  localparam logic [3:0] FUNC_SUB   = 4'b0110;
  localparam logic [3:0] FUNC_PASSB = 4'b0111;
  localparam logic [3:0] FUNC_NOR   = 4'b1100;

  localparam logic [10:0] OPC_ADD = 11'b10001011000;
  localparam logic [10:0] OPC_SUB = 11'b11001011000;
  localparam logic [10:0] OPC_AND = 11'b10001010000;
  localparam logic [10:0] OPC_ORR = 11'b10101010000;

  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] adder_b;
  logic             adder_cin;
  logic [WIDTH-1:0] adder_sum;
  logic [WIDTH-1:0] branch_offset;
  logic [WIDTH-1:0] branch_sum;
  logic [WIDTH-1:0] alu_res;
  logic             zero_flag;

  logic [WIDTH-1:0] alu_result_q,   alu_result_d;
  logic             alu_zero_q,     alu_zero_d;
  logic [WIDTH-1:0] jump_address_q, jump_address_d;

  // ALU control decode
  always_comb begin
    alu_func = FUNC_ADD;
    case (alu_op)
      2'b00:   alu_func = FUNC_ADD;
      2'b01:   alu_func = FUNC_PASSB;
      default: begin
        // alu_op = 1x: R-type, function comes from the opcode
        case (opcode)
          OPC_ADD: alu_func = FUNC_ADD;
          OPC_SUB: alu_func = FUNC_SUB;
          OPC_AND: alu_func = FUNC_AND;
          OPC_ORR: alu_func = FUNC_ORR;
          default: alu_func = FUNC_ADD;
        endcase
      end
    endcase
  end

  assign op_b = alu_src ? extended_data : read_data_2;

  // Subtract reuses the adder as A + ~B + 1.
  assign adder_b   = (alu_func == FUNC_SUB) ? ~op_b : op_b;
  assign adder_cin = (alu_func == FUNC_SUB);

  ex_stage_adder #(.WIDTH(WIDTH)) u_alu_adder (
    .a_i   (read_data_1),
    .b_i   (adder_b),
    .cin_i (adder_cin),
    .sum_o (adder_sum)
  );

  // imm << 2: top two bits fall off, bottom two are zero.
  assign branch_offset = {extended_data[WIDTH-3:0], 2'b00};

  ex_stage_adder #(.WIDTH(WIDTH)) u_branch_adder (
    .a_i   (pc),
    .b_i   (branch_offset),
    .cin_i (1'b0),
    .sum_o (branch_sum)
  );

  always_comb begin
    alu_res = '0;
    case (alu_func)
      FUNC_AND:   alu_res = read_data_1 & op_b;
      FUNC_ORR:   alu_res = read_data_1 | op_b;
      FUNC_ADD:   alu_res = adder_sum;
      FUNC_SUB:   alu_res = adder_sum;
      FUNC_PASSB: alu_res = op_b;
      FUNC_NOR:   alu_res = ~(read_data_1 | op_b);
      default:    alu_res = '0;
    endcase
  end

  assign zero_flag = (alu_res == '0);

  // Next state of the EX/MEM slice: load when enabled, otherwise hold.
  always_comb begin
    alu_result_d   = alu_result_q;
    alu_zero_d     = alu_zero_q;
    jump_address_d = jump_address_q;
    if (register_write) begin
      alu_result_d   = alu_res;
      alu_zero_d     = zero_flag;
      jump_address_d = branch_sum;
    end
  end

  // Reset wins over enable.
  always_ff @(posedge clk) begin
    if (register_reset) begin
      alu_result_q   <= '0;
      alu_zero_q     <= 1'b0;
      jump_address_q <= '0;
    end else begin
      alu_result_q   <= alu_result_d;
      alu_zero_q     <= alu_zero_d;
      jump_address_q <= jump_address_d;
    end
  end

  assign alu_result   = alu_result_q;
  assign alu_zero     = alu_zero_q;
  assign jump_address = jump_address_q;

endmodule

// File: tb/tb_ex_stage_execute_unit.sv
module tb_ex_stage_execute_unit;

  localparam logic [10:0] OPC_ADD = 11'b10001011000;
  localparam logic [10:0] OPC_SUB = 11'b11001011000;
  localparam logic [10:0] OPC_AND = 11'b10001010000;
  localparam logic [10:0] OPC_ORR = 11'b10101010000;
  localparam logic [10:0] OPC_BAD = 11'b11111111111;

  logic        clk;
  logic        register_reset;
  logic        register_write;
  logic [1:0]  alu_op;
  logic        alu_src;
  logic [10:0] opcode;
  logic [63:0] pc;
  logic [63:0] read_data_1;
  logic [63:0] read_data_2;
  logic [63:0] extended_data;
  logic [3:0]  alu_func;
  logic [63:0] alu_result;
  logic        alu_zero;
  logic [63:0] jump_address;

  int compared;
  int mismatched;

  ex_stage_execute_unit #(.WIDTH(64)) dut (
    .clk            (clk),
    .register_reset (register_reset),
    .register_write (register_write),
    .alu_op         (alu_op),
    .alu_src        (alu_src),
    .opcode         (opcode),
    .pc             (pc),
    .read_data_1    (read_data_1),
    .read_data_2    (read_data_2),
    .extended_data  (extended_data),
    .alu_func       (alu_func),
    .alu_result     (alu_result),
    .alu_zero       (alu_zero),
    .jump_address   (jump_address)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One active edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic src, input logic [10:0] opc,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] imm, input logic [63:0] p);
    alu_op        = op;
    alu_src       = src;
    opcode        = opc;
    read_data_1   = a;
    read_data_2   = b;
    extended_data = imm;
    pc            = p;
  endtask

  task automatic check_out(input string tag, input logic [63:0] res,
                           input logic zero, input logic [63:0] jmp);
    check({tag, ".result"}, alu_result, res);
    check({tag, ".zero"}, {63'b0, alu_zero}, {63'b0, zero});
    check({tag, ".jump"}, jump_address, jmp);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    // Reset held 3 edges with nonzero inputs
    register_reset = 1'b1;
    register_write = 1'b1;
    drive(2'b10, 1'b0, OPC_ADD, 64'h55, 64'h66, 64'h7, 64'h200);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("reset", 64'h0, 1'b0, 64'h0);
    end

    // Release reset: first enabled edge captures live inputs
    register_reset = 1'b0;
    drive(2'b00, 1'b0, OPC_ADD, 64'd5, 64'd3, 64'h0, 64'h0);
    #1 check("ldst.func", {60'b0, alu_func}, 64'h2);
    tick();
    check_out("first_add", 64'd8, 1'b0, 64'h0);

    // R-type decode, A=0xF0, B=0x3C
    drive(2'b10, 1'b0, OPC_ADD, 64'hF0, 64'h3C, 64'h0, 64'h0);
    #1 check("radd.func", {60'b0, alu_func}, 64'h2);
    tick();
    check("radd.result", alu_result, 64'h12C);

    drive(2'b10, 1'b0, OPC_SUB, 64'hF0, 64'h3C, 64'h0, 64'h0);
    #1 check("rsub.func", {60'b0, alu_func}, 64'h6);
    tick();
    check("rsub.result", alu_result, 64'hB4);

    drive(2'b10, 1'b0, OPC_AND, 64'hF0, 64'h3C, 64'h0, 64'h0);
    #1 check("rand.func", {60'b0, alu_func}, 64'h0);
    tick();
    check("rand.result", alu_result, 64'h30);

    drive(2'b11, 1'b0, OPC_ORR, 64'hF0, 64'h3C, 64'h0, 64'h0);
    #1 check("rorr.func", {60'b0, alu_func}, 64'h1);
    tick();
    check("rorr.result", alu_result, 64'hFC);

    drive(2'b10, 1'b0, OPC_BAD, 64'hF0, 64'h3C, 64'h0, 64'h0);
    #1 check("rbad.func", {60'b0, alu_func}, 64'h2);
    tick();
    check("rbad.result", alu_result, 64'h12C);

    // Load/store address with negative immediate; jump = 0x1000 - 32
    drive(2'b00, 1'b1, 11'b11111000010, 64'h100, 64'hDEAD, 64'hFFFF_FFFF_FFFF_FFF8, 64'h1000);
    tick();
    check_out("ldur", 64'hF8, 1'b0, 64'hFE0);

    // CBZ, B=0 then B=7
    drive(2'b01, 1'b0, 11'b10110100000, 64'h1234, 64'h0, 64'h3, 64'h40);
    #1 check("cbz.func", {60'b0, alu_func}, 64'h7);
    tick();
    check_out("cbz0", 64'h0, 1'b1, 64'h4C);

    drive(2'b01, 1'b0, 11'b10110100000, 64'h1234, 64'h7, 64'h3, 64'h40);
    tick();
    check_out("cbz7", 64'h7, 1'b0, 64'h4C);

    // Wrap-around and negative branch
    drive(2'b10, 1'b0, OPC_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 64'h0);
    tick();
    check_out("wrap_add", 64'h0, 1'b1, 64'h0);

    drive(2'b10, 1'b0, OPC_SUB, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h10);
    tick();
    check_out("wrap_sub", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h08);

    // Enable low: outputs hold for 4 edges while inputs move
    register_write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(2'b10, 1'b0, OPC_ADD, 64'(i + 1), 64'(i * 3), 64'(i), 64'h300);
      tick();
      check_out("hold", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h08);
    end

    // Re-enable: next edge captures new values
    register_write = 1'b1;
    drive(2'b10, 1'b0, OPC_SUB, 64'h2, 64'h2, 64'h1, 64'h100);
    tick();
    check_out("reenable", 64'h0, 1'b1, 64'h104);

    // Reset mid-stream with a zero-result instruction: zero still reads 0
    drive(2'b10, 1'b0, OPC_ADD, 64'h0, 64'h0, 64'h5, 64'h80);
    register_reset = 1'b1;
    tick();
    check_out("mid_reset", 64'h0, 1'b0, 64'h0);

    register_reset = 1'b0;
    tick();
    check_out("post_reset", 64'h0, 1'b1, 64'h94);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
